noise_wave_gen: RTL and testbench



---
 rtl/noise_wave_gen_pkg.sv | 26 ++
 rtl/noise_wave_gen_if.sv | 26 ++
 rtl/noise_wave_gen_tick_divider.sv | 34 +++
 rtl/noise_wave_gen.sv | 153 +++++++++++++++
 tb/tb_noise_wave_gen.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/noise_wave_gen_pkg.sv
// noise_gen_pkg
// Shared types and constants for the noise/wave test-signal generator.
//   wave_sel_t   : base waveform selector encoding
//   buf_state_t  : output sample buffer occupancy
//   LFSR_W       : width of the upstream free-running LFSR
//   NOISE_OFFSET : bias removed from the LFSR value to centre the noise on 0
//   MAX_GAIN     : largest effective noise_gain code
package noise_gen_pkg;

    localparam int LFSR_W       = 5;
    localparam int NOISE_OFFSET = 16;
    localparam int MAX_GAIN     = 4;

    typedef enum logic [1:0] {
        WAVE_FLAT   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_sel_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/noise_wave_gen_if.sv
// noise_wave_gen_if
// Valid/ready sample stream from the generator to the capture/trigger path.
//   sample_data  : sample value          (master -> slave)
//   sample_valid : sample_data is valid  (master -> slave)
//   sample_ready : consumer accepts      (slave -> master)
interface noise_wave_gen_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/noise_wave_gen_tick_divider.sv
// tick_divider
// Programmable sample-rate timebase: one-cycle tick every div+1 cycles.
//   clk    : system clock
//   rst    : synchronous active-low reset
//   enable : run; when low the counter is held at 0 and no ticks occur
//   div    : tick period minus 1
//   tick   : asserted in the cycle where the count equals div
module tick_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    // Compare against the live div value; if div is lowered below the current
    // count the counter simply runs on, wraps, and ticks when it meets div.
    assign tick = enable && (cnt_q == div);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/noise_wave_gen.sv
// noise_wave_gen
// Synthetic oscilloscope test waveform: phase-accumulated base wave plus
// scaled LFSR noise, saturated, emitted at a programmable rate on a
// valid/ready stream, with a saturating count of samples dropped under
// backpressure.
//   clk        : system clock
//   rst        : synchronous active-low reset
//   enable     : run/hold generator
//   wave_sel   : 0 flat, 1 square, 2 triangle, 3 sawtooth
//   phase_inc  : phase step per sample tick
//   div        : tick period minus 1
//   noise_gain : 0 off, 1..4 noise shift 0..3, 5..7 behave as 4
//   lfsr_in    : current LFSR state
//   smp        : sample stream (master side)
//   drop_cnt   : saturating count of dropped samples
//
// Output buffer states:
//   state      | meaning
//   BUF_EMPTY  | no sample presented, sample_valid=0
//   BUF_FULL   | sample presented, sample_valid=1
module noise_wave_gen
    import noise_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        wave_sel,
    input  logic [DATA_W-1:0] phase_inc,
    input  logic [DIV_W-1:0]  div,
    input  logic [2:0]        noise_gain,
    input  logic [LFSR_W-1:0] lfsr_in,
    noise_wave_gen_if.master  smp,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int SUM_W = DATA_W + 3;

    logic                    tick;
    logic [DATA_W-1:0]       phase_q;
    logic [DATA_W-1:0]       data_q;
    logic [CNT_W-1:0]        drop_q;
    logic [DATA_W-1:0]       base;
    logic [DATA_W-1:0]       sat;
    logic [2:0]              gain_eff;
    logic signed [SUM_W-1:0] noise_raw;
    logic signed [SUM_W-1:0] noise_scaled;
    logic signed [SUM_W-1:0] sum_s;
    wave_sel_t               wave;
    buf_state_t              state_q;
    buf_state_t              state_d;
    logic                    load;
    logic                    drop;

    tick_divider #(
        .DIV_W(DIV_W)
    ) u_tick_divider (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .div    (div),
        .tick   (tick)
    );

    assign wave = wave_sel_t'(wave_sel);

    always_comb begin
        base = '0;
        case (wave)
            WAVE_FLAT:   base = {1'b1, {(DATA_W-1){1'b0}}};
            WAVE_SQUARE: base = {DATA_W{phase_q[DATA_W-1]}};
            WAVE_TRI:    base = phase_q[DATA_W-1] ? ~{phase_q[DATA_W-2:0], 1'b0}
                                                  :  {phase_q[DATA_W-2:0], 1'b0};
            WAVE_SAW:    base = phase_q;
        endcase
    end

    // Noise is the LFSR value re-centred to -16..15, then shifted by gain-1.
    // SUM_W leaves room for the largest shifted noise on top of a full-scale base.
    always_comb begin
        gain_eff     = (noise_gain > 3'(MAX_GAIN)) ? 3'(MAX_GAIN) : noise_gain;
        noise_raw    = $signed({{(SUM_W-LFSR_W){1'b0}}, lfsr_in})
                       - $signed(SUM_W'(NOISE_OFFSET));
        noise_scaled = '0;
        if (gain_eff != 3'd0) begin
            noise_scaled = noise_raw <<< (gain_eff - 3'd1);
        end
        sum_s = $signed({3'b000, base}) + noise_scaled;
        if (sum_s[SUM_W-1]) begin
            sat = '0;
        end else if (|sum_s[SUM_W-2:DATA_W]) begin
            sat = '1;
        end else begin
            sat = sum_s[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (tick) begin
                    load    = 1'b1;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (tick) begin
                    // A sample leaving this cycle frees the slot for the new one.
                    if (smp.sample_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (smp.sample_ready) begin
                    state_d = BUF_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BUF_EMPTY;
            phase_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            // Phase advances on every tick, dropped or not, so the waveform
            // timebase is independent of consumer backpressure.
            if (tick) begin
                phase_q <= phase_q + phase_inc;
            end
            if (load) begin
                data_q <= sat;
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign smp.sample_data  = data_q;
    assign smp.sample_valid = (state_q == BUF_FULL);
    assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_noise_wave_gen.sv
module tb_noise_wave_gen;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  wave_sel;
    logic [7:0]  phase_inc;
    logic [15:0] div;
    logic [2:0]  noise_gain;
    logic [4:0]  lfsr_in;
    logic [7:0]  drop_cnt;

    noise_wave_gen_if #(.DATA_W(8)) smp ();

    noise_wave_gen #(
        .DATA_W(8),
        .DIV_W (16),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wave_sel   (wave_sel),
        .phase_inc  (phase_inc),
        .div        (div),
        .noise_gain (noise_gain),
        .lfsr_in    (lfsr_in),
        .smp        (smp),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int valid_cycles = 0;
    logic [7:0] exp_q[$];

    // Scoreboard monitor: every accepted transfer is compared with the queue head.
    always @(negedge clk) begin
        logic [7:0] e;
        if (smp.sample_valid === 1'b1) valid_cycles++;
        if (rst === 1'b1 && smp.sample_valid === 1'b1 && smp.sample_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sample_unexpected got=%h want=none", smp.sample_data);
            end else begin
                e = exp_q.pop_front();
                if (smp.sample_data !== e) begin
                    bad++;
                    $display("FAIL sample_data got=%h want=%h", smp.sample_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        enable = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic pulse(input int n);
        enable = 1'b1;
        repeat (n) step();
        enable = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            step();
            k++;
        end
        repeat (2) step();
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_drops(input int n);
        int k;
        k = 0;
        while (drop_cnt != 8'(n) && k < 40) begin
            step();
            k++;
        end
    endtask

    typedef struct {
        logic [1:0]  w;
        logic [7:0]  inc;
        logic [2:0]  g;
        logic [4:0]  l;
        int          n;
        logic [31:0] e;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{w: 2'd0, inc: 8'h00, g: 3'd4, l: 5'd0,  n: 1, e: 32'h0000_0000};
        vecs[1] = '{w: 2'd0, inc: 8'h00, g: 3'd4, l: 5'd31, n: 1, e: 32'h0000_00F8};
        vecs[2] = '{w: 2'd1, inc: 8'h80, g: 3'd1, l: 5'd31, n: 2, e: 32'h0000_FF0F};
        vecs[3] = '{w: 2'd1, inc: 8'h00, g: 3'd1, l: 5'd0,  n: 1, e: 32'h0000_0000};
        vecs[4] = '{w: 2'd2, inc: 8'h40, g: 3'd0, l: 5'd9,  n: 4, e: 32'h7FFF_8000};
        vecs[5] = '{w: 2'd0, inc: 8'h00, g: 3'd7, l: 5'd1,  n: 1, e: 32'h0000_0008};
        vecs[6] = '{w: 2'd0, inc: 8'h00, g: 3'd2, l: 5'd20, n: 1, e: 32'h0000_0088};

        // Reset held with generator enabled.
        rst              = 1'b0;
        enable           = 1'b1;
        div              = 16'd0;
        wave_sel         = 2'd0;
        phase_inc        = 8'h00;
        noise_gain       = 3'd0;
        lfsr_in          = 5'd0;
        smp.sample_ready = 1'b0;
        repeat (3) step();
        check("rst_valid", int'(smp.sample_valid), 0);
        check("rst_data", int'(smp.sample_data), 0);
        check("rst_drop", int'(drop_cnt), 0);
        rst = 1'b1;
        step();
        check("first_valid", int'(smp.sample_valid), 1);
        check("first_data", int'(smp.sample_data), 8'h80);
        enable = 1'b0;
        exp_q.push_back(8'h80);
        smp.sample_ready = 1'b1;
        drain("first");

        // Flat wave, back-to-back.
        do_reset();
        wave_sel = 2'd0; div = 16'd0; noise_gain = 3'd0; smp.sample_ready = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h80);
        valid_cycles = 0;
        pulse(10);
        drain("flat");
        check("flat_valid_cycles", valid_cycles, 10);
        check("flat_drop", int'(drop_cnt), 0);

        // Sawtooth at one sample per 4 cycles, including phase wrap.
        do_reset();
        wave_sel = 2'd3; phase_inc = 8'h10; div = 16'd3; noise_gain = 3'd0;
        for (int i = 0; i < 17; i++) exp_q.push_back(8'((i * 16) % 256));
        valid_cycles = 0;
        pulse(68);
        drain("saw");
        check("saw_valid_cycles", valid_cycles, 17);

        // Noise scaling, saturation, triangle shape.
        div = 16'd0;
        for (int v = 0; v < 7; v++) begin
            do_reset();
            wave_sel   = vecs[v].w;
            phase_inc  = vecs[v].inc;
            noise_gain = vecs[v].g;
            lfsr_in    = vecs[v].l;
            for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].e[8*i +: 8]);
            pulse(vecs[v].n);
            drain("noise");
        end

        // Backpressure: five ticks stalled, four dropped.
        do_reset();
        wave_sel = 2'd3; phase_inc = 8'h01; div = 16'd1; noise_gain = 3'd0; lfsr_in = 5'd0;
        smp.sample_ready = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h05);
        enable = 1'b1;
        wait_drops(4);
        check("bp_drop", int'(drop_cnt), 4);
        check("bp_hold_data", int'(smp.sample_data), 0);
        check("bp_hold_valid", int'(smp.sample_valid), 1);
        smp.sample_ready = 1'b1;
        step();
        step();
        enable = 1'b0;
        drain("bp");
        check("bp_drop_after", int'(drop_cnt), 4);

        // Reset in the middle of a stall.
        do_reset();
        smp.sample_ready = 1'b0;
        enable = 1'b1;
        wait_drops(4);
        check("stall_drop", int'(drop_cnt), 4);
        rst = 1'b0;
        step();
        check("mid_rst_valid", int'(smp.sample_valid), 0);
        check("mid_rst_data", int'(smp.sample_data), 0);
        check("mid_rst_drop", int'(drop_cnt), 0);
        rst = 1'b1;
        enable = 1'b0;
        smp.sample_ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        pulse(4);
        drain("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
